muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_div_iter.sv | 43 ++++
 rtl/muldiv_unit.sv | 198 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op encodings, FSM
// states and the iteration count of the bit-serial datapaths.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  localparam int unsigned MD_ITER_CNT = 32;
  localparam int unsigned MD_CNT_W    = $clog2(MD_ITER_CNT);

  // Multiply ops occupy the lower half of the funct3 space.
  function automatic logic md_is_mul(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// Restoring divider on operand magnitudes: one quotient bit per step, MSB first.
// Exposes next-step quotient/remainder so the caller can capture the final step.
module muldiv_div_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quot_nxt,
  output logic [XLEN-1:0] rem_nxt
);

  logic [XLEN-1:0] quot_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dsr_q;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // Dividend bits shift out of the quotient register into the remainder;
  // a borrow in diff[XLEN] means the trial subtraction is discarded.
  always_comb begin
    shifted  = {rem_q, quot_q[XLEN-1]};
    diff     = shifted - {1'b0, dsr_q};
    quot_nxt = {quot_q[XLEN-2:0], ~diff[XLEN]};
    rem_nxt  = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (load) begin
      quot_q <= dividend;
      rem_q  <= '0;
      dsr_q  <= divisor;
    end else if (step) begin
      quot_q <= quot_nxt;
      rem_q  <= rem_nxt;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: bit-serial shift-add multiply and restoring divide.
// Define MULDIV_FAST_MUL_EN to compute multiply ops with a single-cycle multiplier.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int HART_ID_W  = 1,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  muldiv_start,
  input  logic [2:0]            muldiv_op,
  input  logic [XLEN-1:0]       muldiv_a,
  input  logic [XLEN-1:0]       muldiv_b,
  input  logic [HART_ID_W-1:0]  muldiv_hart_id,
  input  logic [REG_ADDR_W-1:0] muldiv_rd,
  output logic                  muldiv_busy,
  output logic                  muldiv_done,
  output logic [XLEN-1:0]       muldiv_result,
  output logic [HART_ID_W-1:0]  muldiv_done_hart_id,
  output logic [REG_ADDR_W-1:0] muldiv_done_rd
);

  localparam logic [MD_CNT_W-1:0] CNT_LAST = MD_CNT_W'(MD_ITER_CNT - 1);

  function automatic logic [2*XLEN-1:0] apply_sign_wide(input logic [2*XLEN-1:0] mag,
                                                         input logic neg);
    return neg ? -mag : mag;
  endfunction

  function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] mag, input logic neg);
    return neg ? -mag : mag;
  endfunction

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
  logic                  accept;
  logic                  last_calc;

  md_op_e                op_in;
  logic                  a_sgn, b_sgn, neg_in;
  logic signed [XLEN:0]  a_ext, b_ext, a_abs, b_abs;
  logic [XLEN-1:0]       a_mag, b_mag;

  md_op_e                op_q;
  logic [XLEN-1:0]       a_q;
  logic                  neg_q;
  logic                  div0_q;
  logic [HART_ID_W-1:0]  hart_q;
  logic [REG_ADDR_W-1:0] rd_q;

  logic [2*XLEN-1:0]     mul_full;
  logic [XLEN-1:0]       quot_nxt, rem_nxt;
  logic [XLEN-1:0]       result_d;

  assign accept      = (state_q == ST_IDLE) && muldiv_start;
  assign muldiv_busy = (state_q != ST_IDLE);
  assign muldiv_done = (state_q == ST_DONE);

  // Operand preparation: 33-bit extension per op signedness, then magnitudes.
  always_comb begin
    op_in  = md_op_e'(muldiv_op);
    a_sgn  = (op_in == MD_MULH) || (op_in == MD_MULHSU) || (op_in == MD_DIV) || (op_in == MD_REM);
    b_sgn  = (op_in == MD_MULH) || (op_in == MD_DIV) || (op_in == MD_REM);
    a_ext  = {a_sgn & muldiv_a[XLEN-1], muldiv_a};
    b_ext  = {b_sgn & muldiv_b[XLEN-1], muldiv_b};
    a_abs  = a_ext[XLEN] ? -a_ext : a_ext;
    b_abs  = b_ext[XLEN] ? -b_ext : b_ext;
    a_mag  = a_abs[XLEN-1:0];
    b_mag  = b_abs[XLEN-1:0];
    // Remainder follows the dividend sign; products and quotients the XOR.
    neg_in = ((op_in == MD_REM) || (op_in == MD_REMU)) ? a_ext[XLEN]
                                                       : (a_ext[XLEN] ^ b_ext[XLEN]);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= op_in;
      a_q    <= muldiv_a;
      neg_q  <= neg_in;
      div0_q <= (muldiv_b == '0);
      hart_q <= muldiv_hart_id;
      rd_q   <= muldiv_rd;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     a_ext_q, b_ext_q;
  logic signed [2*XLEN+1:0] fast_prod;

  always_ff @(posedge clk) begin
    if (accept) begin
      a_ext_q <= a_ext;
      b_ext_q <= b_ext;
    end
  end

  always_comb begin
    fast_prod = a_ext_q * b_ext_q;
    mul_full  = fast_prod[2*XLEN-1:0];
  end

  assign last_calc = md_is_mul(op_q) || (cnt_q == CNT_LAST);
`else
  logic [XLEN-1:0] acc_hi_q, acc_lo_q, mcand_q;
  logic [XLEN-1:0] acc_hi_nxt, acc_lo_nxt;
  logic [XLEN:0]   mul_sum;

  // Shift-add: conditionally add the multiplicand into the upper half, then
  // shift the {hi, lo} pair right; lo starts out holding the multiplier.
  always_comb begin
    mul_sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
    acc_hi_nxt = mul_sum[XLEN:1];
    acc_lo_nxt = {mul_sum[0], acc_lo_q[XLEN-1:1]};
    mul_full   = apply_sign_wide({acc_hi_nxt, acc_lo_nxt}, neg_q);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      acc_hi_q <= '0;
      acc_lo_q <= b_mag;
      mcand_q  <= a_mag;
    end else if (state_q == ST_CALC) begin
      acc_hi_q <= acc_hi_nxt;
      acc_lo_q <= acc_lo_nxt;
    end
  end

  assign last_calc = (cnt_q == CNT_LAST);
`endif

  muldiv_div_iter #(
    .XLEN (XLEN)
  ) u_div_iter (
    .clk      (clk),
    .load     (accept),
    .step     (state_q == ST_CALC),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quot_nxt (quot_nxt),
    .rem_nxt  (rem_nxt)
  );

  // Final result is formed from the last step's next values so it lands in DONE.
  always_comb begin
    result_d = '0;
    case (op_q)
      MD_MUL:                      result_d = mul_full[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result_d = mul_full[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             result_d = div0_q ? '1 : apply_sign(quot_nxt, neg_q);
      MD_REM, MD_REMU:             result_d = div0_q ? a_q : apply_sign(rem_nxt, neg_q);
      default:                     result_d = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (muldiv_start) begin
          state_d = ST_CALC;
          cnt_d   = '0;
        end
      end
      ST_CALC: begin
        if (last_calc) state_d = ST_DONE;
        else           cnt_d   = cnt_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      muldiv_result       <= '0;
      muldiv_done_hart_id <= '0;
      muldiv_done_rd      <= '0;
    end else if ((state_q == ST_CALC) && last_calc) begin
      muldiv_result       <= result_d;
      muldiv_done_hart_id <= hart_q;
      muldiv_done_rd      <= rd_q;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit with hand-computed expectations.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        muldiv_start = 1'b0;
  logic [2:0]  muldiv_op = 3'd0;
  logic [31:0] muldiv_a = '0;
  logic [31:0] muldiv_b = '0;
  logic [0:0]  muldiv_hart_id = '0;
  logic [4:0]  muldiv_rd = '0;
  logic        muldiv_busy;
  logic        muldiv_done;
  logic [31:0] muldiv_result;
  logic [0:0]  muldiv_done_hart_id;
  logic [4:0]  muldiv_done_rd;

  int n_checks = 0;
  int n_pass   = 0;

  muldiv_unit #(.XLEN(32), .HART_ID_W(1), .REG_ADDR_W(5)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .muldiv_start        (muldiv_start),
    .muldiv_op           (muldiv_op),
    .muldiv_a            (muldiv_a),
    .muldiv_b            (muldiv_b),
    .muldiv_hart_id      (muldiv_hart_id),
    .muldiv_rd           (muldiv_rd),
    .muldiv_busy         (muldiv_busy),
    .muldiv_done         (muldiv_done),
    .muldiv_result       (muldiv_result),
    .muldiv_done_hart_id (muldiv_done_hart_id),
    .muldiv_done_rd      (muldiv_done_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic int exp_lat(input logic [2:0] op);
`ifdef MULDIV_FAST_MUL_EN
    return (op < 3'd4) ? 2 : 33;
`else
    return 33;
`endif
  endfunction

  // Issue one request, then count falling edges until done (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic hart, input logic [4:0] rd,
                        output int lat, output logic busy_ok);
    @(negedge clk);
    muldiv_start = 1'b1; muldiv_op = op; muldiv_a = a; muldiv_b = b;
    muldiv_hart_id = hart; muldiv_rd = rd;
    @(posedge clk);
    #1 muldiv_start = 1'b0;
    lat = 0; busy_ok = 1'b1;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (!muldiv_busy) busy_ok = 1'b0;
      if (muldiv_done) break;
    end
  endtask

  task automatic exec(input string tag, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
    int   lat;
    logic bok;
    run_op(op, a, b, 1'b0, 5'd0, lat, bok);
    check({tag, "_lat"}, lat, exp_lat(op));
    check({tag, "_res"}, muldiv_result, exp);
  endtask

  initial begin
    int   lat, cnt, pulses;
    logic bok;

    #12;
    check("rst_busy", {31'd0, muldiv_busy}, 32'd0);
    check("rst_done", {31'd0, muldiv_done}, 32'd0);
    check("rst_result", muldiv_result, 32'd0);
    check("rst_hart", {31'd0, muldiv_done_hart_id}, 32'd0);
    check("rst_rd", {27'd0, muldiv_done_rd}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(3'd0, 32'd7, 32'd6, 1'b1, 5'd3, lat, bok);
    check("mul_lat", lat, exp_lat(3'd0));
    check("mul_res", muldiv_result, 32'd42);
    check("mul_hart", {31'd0, muldiv_done_hart_id}, 32'd1);
    check("mul_rd", {27'd0, muldiv_done_rd}, 32'd3);
    check("mul_busy", {31'd0, bok}, 32'd1);
    repeat (3) @(negedge clk);
    check("hold_res", muldiv_result, 32'd42);
    check("hold_done", {31'd0, muldiv_done}, 32'd0);
    check("hold_rd", {27'd0, muldiv_done_rd}, 32'd3);

    exec("mulh",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    exec("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    exec("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF);
    exec("mul_neg", 3'd0, 32'hFFFFFFFD, 32'd5,       32'hFFFFFFF1);
    exec("div",    3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
    exec("rem",    3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
    exec("divu0",  3'd5, 32'd100,      32'd0,        32'hFFFFFFFF);
    exec("remu0",  3'd7, 32'd100,      32'd0,        32'd100);
    exec("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    exec("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);
    exec("divu",   3'd5, 32'd1000,     32'd7,        32'd142);
    exec("remu",   3'd7, 32'd1000,     32'd7,        32'd6);

    // Start held high through CALC with new operands; second request taken after DONE.
    @(negedge clk);
    muldiv_start = 1'b1; muldiv_op = 3'd4; muldiv_a = 32'd100; muldiv_b = 32'd7;
    @(posedge clk);
    #1 muldiv_op = 3'd5; muldiv_a = 32'd50; muldiv_b = 32'd5; muldiv_rd = 5'd9;
    cnt = 0;
    while (cnt < 60) begin
      @(negedge clk);
      cnt++;
      if (muldiv_done) break;
    end
    check("b2b_first_lat", cnt, 32'd33);
    check("b2b_first_res", muldiv_result, 32'd14);
    cnt = 0;
    while (cnt < 60) begin
      @(negedge clk);
      cnt++;
      if (muldiv_done) break;
    end
    muldiv_start = 1'b0;
    check("b2b_gap", cnt, 32'd34);
    check("b2b_second_res", muldiv_result, 32'd10);
    check("b2b_second_rd", {27'd0, muldiv_done_rd}, 32'd9);
    repeat (2) @(negedge clk);

    // Reset in the middle of CALC aborts with no later done pulse.
    @(negedge clk);
    muldiv_start = 1'b1; muldiv_op = 3'd4; muldiv_a = 32'd77; muldiv_b = 32'd3;
    @(posedge clk);
    #1 muldiv_start = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_busy_before", {31'd0, muldiv_busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, muldiv_busy}, 32'd0);
    check("abort_done", {31'd0, muldiv_done}, 32'd0);
    check("abort_result", muldiv_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (muldiv_done) pulses++;
    end
    check("abort_no_done", pulses, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
